// File: rtl/hd_unload_streamer.sv
// Frame unloader: issues credit-gated row reads to the HD column memories and
// serialises each captured KB*HDDW row into HDDW-bit beats on a valid/ready stream.
module hd_unload_streamer #(
  parameter int KB           = 14,
  parameter int HDDW         = 32,
  parameter int UNLOADCOUNT  = 17,
  parameter int ADDRESSWIDTH = 5,
  parameter int FIFODEPTH    = 4,
  parameter int RDLAT        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    unload_start,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unload_addr,
  input  logic [KB*HDDW-1:0]      wrdin_vec,
  output logic [HDDW-1:0]         hd_out,
  output logic                    hd_valid,
  input  logic                    hd_ready,
  output logic                    hd_last,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int RW = KB * HDDW;
  localparam int EW = RW + 1;
  localparam int BW = (KB > 1) ? $clog2(KB) : 1;
  localparam int PW = $clog2(FIFODEPTH);
  localparam int CW = $clog2(FIFODEPTH + 1);

  localparam logic [BW-1:0]           BEAT_LAST = BW'(KB - 1);
  localparam logic [ADDRESSWIDTH-1:0] ROW_LAST  = ADDRESSWIDTH'(UNLOADCOUNT - 1);
  localparam logic [PW-1:0]           PTR_LAST  = PW'(FIFODEPTH - 1);
  localparam logic [CW-1:0]           DEPTH     = CW'(FIFODEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q;
  logic [ADDRESSWIDTH-1:0] row_q;
  logic                    unload_en_q;
  logic                    unload_last_q;
  logic [ADDRESSWIDTH-1:0] unload_addr_q;
  logic [RDLAT-1:0]        pipe_vld_q;
  logic [RDLAT-1:0]        pipe_last_q;
  logic [EW-1:0]           mem_q [FIFODEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, cred_q;
  logic [BW-1:0]           beat_q;
  logic [HDDW-1:0]         hd_out_q;
  logic                    hd_valid_q, hd_last_q, busy_q, frame_done_q;

  logic                    xfer, pop, push, issue, issue_last;
  logic [ADDRESSWIDTH-1:0] issue_row;
  logic [PW-1:0]           rd_ptr_d, wr_ptr_d;
  logic [CW-1:0]           count_d, cred_d;
  logic [BW-1:0]           beat_d;
  logic [EW-1:0]           head;
  logic [HDDW-1:0]         hd_out_d;
  logic                    hd_valid_d, hd_last_d;

  // Row 0 is issued straight from IDLE so unload_en follows the start pulse by
  // one cycle; credit is always full in IDLE because the previous frame has drained.
  always_comb begin
    xfer       = hd_valid_q & hd_ready;
    pop        = xfer & (beat_q == BEAT_LAST);
    push       = pipe_vld_q[RDLAT-1];
    issue_row  = (state_q == IDLE) ? '0 : row_q;
    issue_last = (issue_row == ROW_LAST);
    issue      = ((state_q == IDLE) & unload_start) |
                 ((state_q == ISSUE) & (cred_q < DEPTH));

    cred_d  = cred_q + CW'(issue) - CW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;

    beat_d = beat_q;
    if (xfer) beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;

    // The new head is the row being written this edge only when the FIFO drains to empty.
    if (push && (wr_ptr_q == rd_ptr_d)) head = {pipe_last_q[RDLAT-1], wrdin_vec};
    else                                head = mem_q[rd_ptr_d];

    hd_valid_d = (count_d != '0);
    hd_out_d   = hd_valid_d ? head[beat_d*HDDW +: HDDW] : '0;
    hd_last_d  = hd_valid_d & head[RW] & (beat_d == BEAT_LAST);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pipe_last_q[RDLAT-1], wrdin_vec};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      row_q         <= '0;
      unload_en_q   <= 1'b0;
      unload_last_q <= 1'b0;
      unload_addr_q <= '0;
      pipe_vld_q    <= '0;
      pipe_last_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cred_q        <= '0;
      beat_q        <= '0;
      hd_out_q      <= '0;
      hd_valid_q    <= 1'b0;
      hd_last_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      unload_en_q <= issue;
      if (issue) begin
        unload_addr_q <= issue_row;
        unload_last_q <= issue_last;
        row_q         <= issue_row + 1'b1;
      end

      pipe_vld_q[0]  <= unload_en_q;
      pipe_last_q[0] <= unload_en_q & unload_last_q;
      for (int unsigned i = 1; i < RDLAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end

      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cred_q     <= cred_d;
      beat_q     <= beat_d;
      hd_out_q   <= hd_out_d;
      hd_valid_q <= hd_valid_d;
      hd_last_q  <= hd_last_d;

      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (unload_start) begin
            busy_q  <= 1'b1;
            state_q <= issue_last ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (issue && issue_last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (xfer && hd_last_q) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign unload_en   = unload_en_q;
  assign unload_addr = unload_addr_q;
  assign hd_out      = hd_out_q;
  assign hd_valid    = hd_valid_q;
  assign hd_last     = hd_last_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hd_unload_streamer.sv
// Directed bench: two default-geometry instances (deep and shallow FIFO) sharing
// stimulus, plus a minimal KB=1 configuration instance.
module tb_hd_unload_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, ready, start_c, ready_c;
  logic [7:0] salt;
  logic       rand_mode;
  int         checks = 0;
  int         errors = 0;

  logic         en_a, valid_a, last_a, busy_a, done_a;
  logic [4:0]   addr_a;
  logic [31:0]  out_a;
  logic [447:0] wrdin_a;
  logic         en_b, valid_b, last_b, busy_b, done_b;
  logic [4:0]   addr_b;
  logic [31:0]  out_b;
  logic [447:0] wrdin_b;
  logic         en_c, valid_c, last_c, busy_c, done_c;
  logic [0:0]   addr_c;
  logic [7:0]   out_c, wrdin_c;

  hd_unload_streamer #(.FIFODEPTH(32)) dut_a (
    .clk(clk), .rst(rst), .unload_start(start), .unload_en(en_a), .unload_addr(addr_a),
    .wrdin_vec(wrdin_a), .hd_out(out_a), .hd_valid(valid_a), .hd_ready(ready),
    .hd_last(last_a), .busy(busy_a), .frame_done(done_a));

  hd_unload_streamer #(.FIFODEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .unload_start(start), .unload_en(en_b), .unload_addr(addr_b),
    .wrdin_vec(wrdin_b), .hd_out(out_b), .hd_valid(valid_b), .hd_ready(ready),
    .hd_last(last_b), .busy(busy_b), .frame_done(done_b));

  hd_unload_streamer #(.KB(1), .HDDW(8), .UNLOADCOUNT(1), .ADDRESSWIDTH(1), .FIFODEPTH(2), .RDLAT(1)) dut_c (
    .clk(clk), .rst(rst), .unload_start(start_c), .unload_en(en_c), .unload_addr(addr_c),
    .wrdin_vec(wrdin_c), .hd_out(out_c), .hd_valid(valid_c), .hd_ready(ready_c),
    .hd_last(last_c), .busy(busy_c), .frame_done(done_c));

  function automatic logic [31:0] word(input logic [4:0] row, input int k, input logic [7:0] s);
    return {s, 3'b000, row, 8'(k), 8'hC3};
  endfunction

  // Memory model: data appears RDLAT cycles after the request.
  logic [4:0] apa0, apa1, apb0, apb1;
  logic [0:0] apc0;
  always @(posedge clk) begin
    apa0 <= addr_a; apa1 <= apa0;
    apb0 <= addr_b; apb1 <= apb0;
    apc0 <= addr_c;
  end
  always_comb begin
    wrdin_a = '0;
    wrdin_b = '0;
    for (int k = 0; k < 14; k++) begin
      wrdin_a[k*32 +: 32] = word(apa1, k, salt);
      wrdin_b[k*32 +: 32] = word(apb1, k, salt);
    end
    wrdin_c = 8'h3C ^ {7'b0, apc0};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int bi_a, ea_a, en_cnt_a, fcnt_a;
  logic dn_a;
  int bi_b, ea_b, en_cnt_b, fcnt_b;
  logic dn_b;

  initial begin
    bi_a = 0; ea_a = 0; en_cnt_a = 0; fcnt_a = 0; dn_a = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bi_a = 0; ea_a = 0; dn_a = 1'b0;
      end else begin
        if (en_a) begin
          check("addr_a", 64'(addr_a), 64'(ea_a));
          ea_a = (ea_a == 16) ? 0 : ea_a + 1;
          en_cnt_a++;
        end
        check("fdone_a", 64'(done_a), 64'(dn_a));
        if (done_a) fcnt_a++;
        dn_a = 1'b0;
        if (valid_a && ready) begin
          check("beat_a", 64'(out_a), 64'(word(5'(bi_a / 14), bi_a % 14, salt)));
          check("last_a", 64'(last_a), 64'(bi_a == 237));
          if (bi_a == 237) begin bi_a = 0; dn_a = 1'b1; end
          else bi_a++;
        end
      end
    end
  end

  initial begin
    bi_b = 0; ea_b = 0; en_cnt_b = 0; fcnt_b = 0; dn_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bi_b = 0; ea_b = 0; dn_b = 1'b0;
      end else begin
        if (en_b) begin
          check("addr_b", 64'(addr_b), 64'(ea_b));
          ea_b = (ea_b == 16) ? 0 : ea_b + 1;
          en_cnt_b++;
        end
        check("fdone_b", 64'(done_b), 64'(dn_b));
        if (done_b) fcnt_b++;
        dn_b = 1'b0;
        if (valid_b && ready) begin
          check("beat_b", 64'(out_b), 64'(word(5'(bi_b / 14), bi_b % 14, salt)));
          check("last_b", 64'(last_b), 64'(bi_b == 237));
          if (bi_b == 237) begin bi_b = 0; dn_b = 1'b1; end
          else bi_b++;
        end
      end
    end
  end

  task automatic wait_done(input int t);
    int n;
    n = 0;
    while ((fcnt_a < t || fcnt_b < t) && n < 3000) begin
      if (rand_mode) ready = 1'($urandom_range(0, 1));
      tick;
      n++;
    end
    check("frames_a", 64'(fcnt_a), 64'(t));
    check("frames_b", 64'(fcnt_b), 64'(t));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    rst = 1'b0; start = 1'b0; start_c = 1'b0; ready = 1'b1; ready_c = 1'b1;
    salt = 8'h11; rand_mode = 1'b0;
    repeat (3) tick;
    check("rst_a", 64'({en_a, addr_a, out_a, valid_a, last_a, busy_a, done_a}), 64'd0);
    check("rst_c", 64'({en_c, addr_c, out_c, valid_c, last_c, busy_c, done_c}), 64'd0);
    rst = 1'b1;
    tick;

    // Basic frame on the deep-FIFO instance, cycle-exact.
    start = 1'b1;
    for (int c = 1; c <= 242; c++) begin
      tick;
      start = 1'b0;
      check("bas_en", 64'(en_a), 64'(c <= 17));
      if (c <= 17) check("bas_addr", 64'(addr_a), 64'(c - 1));
      check("bas_valid", 64'(valid_a), 64'(c >= 4 && c <= 241));
      check("bas_last", 64'(last_a), 64'(c == 241));
      check("bas_done", 64'(done_a), 64'(c == 242));
      check("bas_busy", 64'(busy_a), 64'(c <= 241));
    end
    tick;
    check("bas_frames", 64'(fcnt_b), 64'd1);
    nf = 1;

    // Backpressure: shallow FIFO fills with 4 rows and holds its head beat.
    salt = 8'h22; ready = 1'b0; en_cnt_b = 0;
    start = 1'b1; tick; start = 1'b0;
    repeat (20) tick;
    check("bp_en_cnt", 64'(en_cnt_b), 64'd4);
    check("bp_en", 64'(en_b), 64'd0);
    check("bp_valid", 64'(valid_b), 64'd1);
    check("bp_out", 64'(out_b), 64'(word(5'd0, 0, 8'h22)));
    check("bp_last", 64'(last_b), 64'd0);
    repeat (5) tick;
    check("bp_out_hold", 64'(out_b), 64'(word(5'd0, 0, 8'h22)));
    check("bp_en_cnt2", 64'(en_cnt_b), 64'd4);
    ready = 1'b1;
    nf++;
    wait_done(nf);
    check("bp_rows", 64'(en_cnt_b), 64'd17);

    // Random ready over 10 frames.
    rand_mode = 1'b1;
    for (int f = 0; f < 10; f++) begin
      salt = 8'(8'h30 + f);
      start = 1'b1; tick; start = 1'b0;
      nf++;
      wait_done(nf);
    end
    rand_mode = 1'b0; ready = 1'b1;
    tick;

    // Start while busy is ignored; start in the frame_done cycle is taken.
    salt = 8'h44;
    start = 1'b1; tick; start = 1'b0;
    repeat (30) tick;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 400 && !done_a; i++) tick;
    check("fd_seen", 64'(done_a), 64'd1);
    check("fd_busy", 64'(busy_a), 64'd0);
    start = 1'b1; tick; start = 1'b0;
    check("fd_restart_en", 64'(en_a), 64'd1);
    check("fd_restart_addr", 64'(addr_a), 64'd0);
    check("fd_restart_busy", 64'(busy_a), 64'd1);
    nf += 2;
    wait_done(nf);

    // Asynchronous reset mid-frame.
    salt = 8'h55;
    start = 1'b1; tick; start = 1'b0;
    repeat (40) tick;
    rst = 1'b0;
    #1;
    check("arst_a", 64'({en_a, addr_a, out_a, valid_a, last_a, busy_a, done_a}), 64'd0);
    check("arst_b", 64'({en_b, addr_b, out_b, valid_b, last_b, busy_b, done_b}), 64'd0);
    tick; tick;
    rst = 1'b1;
    tick;
    start = 1'b1; tick; start = 1'b0;
    check("arst_en", 64'(en_a), 64'd1);
    check("arst_addr", 64'(addr_a), 64'd0);
    nf++;
    wait_done(nf);

    // Minimal configuration: one row, one beat.
    start_c = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      start_c = 1'b0;
      check("c_en", 64'(en_c), 64'(c == 1));
      if (c == 1) check("c_addr", 64'(addr_c), 64'd0);
      check("c_valid", 64'(valid_c), 64'(c == 3));
      if (c == 3) check("c_out", 64'(out_c), 64'h3C);
      check("c_last", 64'(last_c), 64'(c == 3));
      check("c_busy", 64'(busy_c), 64'(c <= 3));
      check("c_done", 64'(done_c), 64'(c == 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hd_unload_streamer.md
Name: hd_unload_streamer

Overview:
- Parametrised successor to the decoder output interface: unloads a decoded frame of hard-decision (HD) words from the KB column memories and streams it out.
- Issues UNLOADCOUNT row reads and captures each KB*HDDW-bit row into a credit-controlled FIFO.
- Serialises each row into KB beats of HDDW bits on a valid/ready stream with frame-last marking.
- Single clock domain. Replaces the fixed two-clock variant and adds output backpressure, configurable read latency and a frame-done indication.

Parameters:
- KB, 14, number of HD channels (column blocks) per row
- HDDW, 32, bits per channel word and per output beat
- UNLOADCOUNT, 17, rows per frame; must satisfy UNLOADCOUNT <= 2^ADDRESSWIDTH
- ADDRESSWIDTH, 5, row address width
- FIFODEPTH, 4, row-entry capacity of internal FIFO; must be >= 2
- RDLAT, 2, cycles from unload_en to valid wrdin_vec; must be >= 1

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous active-low reset
- unload_start  in  1  one-cycle pulse; starts a frame unload
- unload_en  out  1  row read request to HD memories
- unload_addr  out  ADDRESSWIDTH  row address, valid while unload_en=1
- wrdin_vec  in  KB*HDDW  row read data; valid exactly RDLAT cycles after the matching unload_en; channel k at bits [k*HDDW +: HDDW]
- hd_out  out  HDDW  output beat data
- hd_valid  out  1  hd_out valid
- hd_ready  in  1  downstream accepts beat
- hd_last  out  1  final beat of frame; qualified by hd_valid
- busy  out  1  frame unload in progress
- frame_done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM to IDLE, FIFO emptied, in-flight reads discarded, row and beat counters 0. All outputs are driven from flops.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: unload_start=1 moves to ISSUE with row=0 and busy=1 on the next edge. unload_start is ignored in ISSUE and DRAIN; no queuing.
  - ISSUE: each cycle with credit, register unload_en=1 and unload_addr=row, then row++. After row UNLOADCOUNT-1 is issued, go to DRAIN.
  - DRAIN: wait for acceptance of the beat with hd_last=1. On that edge, go to IDLE with busy=0 and frame_done=1 for one cycle.
- Credit rule: issue only if (FIFO occupancy + reads in flight) < FIFODEPTH. A pop in the same cycle is not credited, which is conservative. The FIFO therefore never overflows and wrdin_vec is never dropped.
- Read pipeline: an RDLAT-stage shift register carries the valid flag and a last-row flag. When a stage exits, the row is written to the FIFO on that edge.
- Latency with ready=1 and FIFO empty:
  - unload_start sampled at edge E0; unload_en=1 in cycle 1.
  - Data valid in cycle 1+RDLAT; hd_valid=1 from cycle 2+RDLAT (cycle 4 by default).
- Serialisation:
  - Head entry emits beat b=0..KB-1 with hd_out = entry[b*HDDW +: HDDW], channel 0 first.
  - A transfer occurs when hd_valid & hd_ready; b increments on each transfer.
  - Transfer at b=KB-1 pops the entry and resets b to 0.
  - hd_valid=1 whenever the FIFO is non-empty. hd_out and hd_last hold stable while hd_valid & !hd_ready.
- hd_last=1 only when b=KB-1 and the head entry carries the last-row flag.
- Write and pop in the same cycle are both performed; occupancy is unchanged.
- Full throughput: with hd_ready held 1, the stream is gapless once primed. Frame length is KB*UNLOADCOUNT beats.
- frame_done cycle: busy=0 in this cycle, so an unload_start in the same cycle is accepted.
- FIFO pointers wrap modulo FIFODEPTH. Non-power-of-2 depths are supported.

Test Plan:
- Reset: assert rst=0 mid-frame -> all outputs 0 immediately (without a clock edge). After release, unload_start -> unload_addr starts at 0 and a full 238-beat frame follows.
- Basic frame, defaults with FIFODEPTH=32 and hd_ready=1:
  - unload_start -> unload_en on 17 consecutive cycles with addresses 0..16.
  - First hd_valid 4 cycles after start.
  - 238 gapless beats in row-major, channel-0-first order matching the memory model.
  - hd_last on beat 238; frame_done one cycle after.
- Backpressure, FIFODEPTH=4 with hd_ready=0 -> exactly 4 unload_en pulses, then unload_en stays 0 and hd_out/hd_last stay stable. Raise hd_ready -> issuing resumes and all 238 beats arrive intact.
- Random hd_ready (50% toggle) over 10 frames -> beat stream equals the scoreboard exactly, hd_last once per frame, no overflow.
- Start while busy: pulse unload_start mid-frame -> ignored, addresses stay sequential. Pulse unload_start in the frame_done cycle -> new frame starts, unload_addr=0 next cycle.
- Config sweep: KB=1, HDDW=8, UNLOADCOUNT=1, RDLAT=1 -> one unload_en, one beat with hd_last=1, frame_done pulse, then busy=0.
